// File: rtl/minisys_timer_n_if.sv
// minisys_timer_n_if: MemOrIo chip-select bus between the CPU side and the timer peripheral.
interface minisys_timer_n_if #(
    parameter int CH_W = 1
);
    logic            timercs;
    logic            ioread;
    logic            iowrite;
    logic [CH_W+1:0] timeraddr;
    logic [15:0]     timerwdata;
    logic [15:0]     timerrdata;
    modport master (output timercs, ioread, iowrite, timeraddr, timerwdata, input timerrdata);
    modport slave (input timercs, ioread, iowrite, timeraddr, timerwdata, output timerrdata);
endinterface

// File: rtl/minisys_timer_n.sv
// minisys_timer_n: multi-channel down-counting timer/counter with sticky done, expiry pulse and irq.
module minisys_timer_n #(
    parameter int NUM_CH = 2,
    parameter int CNT_W = 16
) (
    input logic               clock,
    input logic               reset,
    minisys_timer_n_if.slave  bus,
    input logic [NUM_CH-1:0]  pulse_in,
    output logic [NUM_CH-1:0] cout,
    output logic              irq
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);
    logic [1:0]        sel;
    logic [CH_W-1:0]   ch;
    logic              wr;
    logic              rd;
    logic [15:0]       rd_word [NUM_CH];
    logic [NUM_CH-1:0] irq_v;
    always_comb begin
        sel = bus.timeraddr[1:0];
        ch = bus.timeraddr[CH_W+1:2];
        wr = bus.timercs && bus.iowrite && ({1'b0, ch} < NCH);
        rd = bus.timercs && bus.ioread && ({1'b0, ch} < NCH);
        bus.timerrdata = rd ? rd_word[ch] : '0;
        irq = |irq_v;
    end
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             en;
        logic             periodic;
        logic             ext;
        logic             ie;
        logic             done;
        logic             err;
        logic             s1;
        logic             s2;
        logic             s3;
        logic             cout_r;
        logic [CNT_W-1:0] load;
        logic [CNT_W-1:0] count;
        logic             hit;
        logic             wr_ctrl;
        logic             wr_load;
        logic             rd_stat;
        logic             tick;
        logic             expire;
        logic             start;
        always_comb begin
            hit = ch == CH_W'(c);
            wr_ctrl = wr && hit && sel == 2'd0;
            wr_load = wr && hit && sel == 2'd2;
            rd_stat = rd && hit && sel == 2'd1;
            // s3 is the edge register: a tick is the first cycle s2 is seen high
            tick = ext ? s2 && !s3 : 1'b1;
            expire = en && tick && count == CNT_W'(1);
            start = wr_ctrl && bus.timerwdata[0] && load != '0;
        end
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                {en, periodic, ext, ie, done, err, s1, s2, s3, cout_r} <= '0;
                load <= '0;
                count <= '0;
            end else begin
                s1 <= pulse_in[c];
                s2 <= s1;
                s3 <= s2;
                cout_r <= expire;
                done <= expire || (done && !rd_stat);
                err <= (wr_ctrl && bus.timerwdata[0] && load == '0) || (err && !rd_stat);
                if (wr_load) load <= bus.timerwdata[CNT_W-1:0];
                // a CTRL write overrides any expiry on the same edge; done still latches above
                if (wr_ctrl) begin
                    {ie, ext, periodic} <= bus.timerwdata[3:1];
                    en <= start;
                    if (start) count <= load;
                end else if (expire) begin
                    count <= periodic ? load : '0;
                    en <= periodic;
                end else if (en && tick && count > CNT_W'(1)) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
        assign rd_word[c] = sel == 2'd0 ? {12'd0, ie, ext, periodic, en} :
                            sel == 2'd1 ? {13'd0, err, en, done} :
                            sel == 2'd2 ? 16'(load) : 16'(count);
        assign cout[c] = cout_r;
        assign irq_v[c] = done && ie;
    end
endmodule

// File: tb/tb_minisys_timer_n.sv
// tb_minisys_timer_n: scenario tasks plus randomized periodic/one-shot runs checked against arithmetic expiry rules.
module tb_minisys_timer_n;
    localparam int NUM_CH = 5;
    localparam int CNT_W = 8;
    localparam int CH_W = 3;
    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NUM_CH-1:0] pulse_in = '0;
    logic [NUM_CH-1:0] cout;
    logic              irq;
    int                cyc = 0;
    int                pass_cnt = 0;
    int                tot = 0;
    int                mload [NUM_CH];
    minisys_timer_n_if #(.CH_W(CH_W)) bus ();
    minisys_timer_n #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .bus(bus), .pulse_in(pulse_in), .cout(cout), .irq(irq)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic idle();
        bus.timercs = 1'b0;
        bus.ioread = 1'b0;
        bus.iowrite = 1'b0;
        bus.timeraddr = '0;
        bus.timerwdata = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input int c, input int s, input logic [15:0] d);
        bus.timercs = 1'b1;
        bus.iowrite = 1'b1;
        bus.timeraddr = {3'(c), 2'(s)};
        bus.timerwdata = d;
        step();
        idle();
        if (c < NUM_CH && s == 2) mload[c] = int'(d) & ((1 << CNT_W) - 1);
    endtask

    task automatic peek(input int c, input int s, output logic [15:0] v);
        bus.timercs = 1'b1;
        bus.ioread = 1'b1;
        bus.timeraddr = {3'(c), 2'(s)};
        #1;
        v = bus.timerrdata;
        idle();
    endtask

    task automatic rd_edge(input int c, input int s, output logic [15:0] v);
        bus.timercs = 1'b1;
        bus.ioread = 1'b1;
        bus.timeraddr = {3'(c), 2'(s)};
        #1;
        v = bus.timerrdata;
        step();
        idle();
    endtask

    task automatic test_reset();
        logic [15:0] v;
        wr(1, 2, 16'd1);
        wr(1, 0, 16'h9);
        step();
        tot++; if (irq !== 1'b1) $display("FAIL reset_pre_irq got %b exp 1", irq); else pass_cnt++;
        wr(0, 2, 16'd5);
        wr(0, 0, 16'h9);
        step();
        reset = 1'b0;
        #1;
        tot++; if (cout !== '0) $display("FAIL reset_cout got %b exp 0", cout); else pass_cnt++;
        tot++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else pass_cnt++;
        peek(0, 3, v);
        tot++; if (v !== 16'h0) $display("FAIL reset_rdata got %h exp 0", v); else pass_cnt++;
        step();
        step();
        reset = 1'b1;
        foreach (mload[i]) mload[i] = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            tot++; if (cout !== '0) $display("FAIL reset_no_resume i=%0d got %b exp 0", i, cout); else pass_cnt++;
        end
        for (int s = 0; s < 4; s++) begin
            peek(0, s, v);
            tot++; if (v !== 16'h0) $display("FAIL reset_ch0_reg%0d got %h exp 0", s, v); else pass_cnt++;
            step();
        end
        peek(1, 1, v);
        tot++; if (v !== 16'h0) $display("FAIL reset_ch1_status got %h exp 0", v); else pass_cnt++;
    endtask

    task automatic test_oneshot();
        logic [15:0] v;
        wr(0, 2, 16'd5);
        wr(0, 0, 16'h9);
        for (int k = 1; k <= 7; k++) begin
            step();
            tot++; if (cout[0] !== (k == 5)) $display("FAIL oneshot_cout k=%0d got %b exp %b", k, cout[0], k == 5); else pass_cnt++;
            peek(0, 3, v);
            tot++; if (v !== 16'(k < 5 ? 5 - k : 0)) $display("FAIL oneshot_count k=%0d got %0d exp %0d", k, v, k < 5 ? 5 - k : 0); else pass_cnt++;
        end
        tot++; if (irq !== 1'b1) $display("FAIL oneshot_irq got %b exp 1", irq); else pass_cnt++;
        rd_edge(0, 1, v);
        tot++; if (v !== 16'h1) $display("FAIL oneshot_status1 got %h exp 1", v); else pass_cnt++;
        tot++; if (irq !== 1'b0) $display("FAIL oneshot_irq_clr got %b exp 0", irq); else pass_cnt++;
        peek(0, 1, v);
        tot++; if (v !== 16'h0) $display("FAIL oneshot_status2 got %h exp 0", v); else pass_cnt++;
    endtask

    task automatic test_periodic();
        logic [15:0] v;
        bit e;
        int ce;
        wr(1, 2, 16'd3);
        wr(1, 0, 16'h3);
        for (int k = 1; k <= 50; k++) begin
            if (k == 31) wr(1, 2, 16'd7); else step();
            e = k <= 33 ? k % 3 == 0 : (k - 33) % 7 == 0;
            ce = k < 33 ? 3 - k % 3 : 7 - (k - 33) % 7;
            tot++; if (cout[1] !== e) $display("FAIL periodic_cout k=%0d got %b exp %b", k, cout[1], e); else pass_cnt++;
            peek(1, 3, v);
            tot++; if (v !== 16'(ce)) $display("FAIL periodic_count k=%0d got %0d exp %0d", k, v, ce); else pass_cnt++;
        end
        wr(1, 0, 16'h0);
        repeat (3) step();
        peek(1, 3, v);
        tot++; if (v !== 16'(7 - (50 - 33) % 7)) $display("FAIL periodic_hold got %0d exp %0d", v, 7 - (50 - 33) % 7); else pass_cnt++;
        rd_edge(1, 1, v);
        tot++; if (v !== 16'h1) $display("FAIL periodic_status got %h exp 1", v); else pass_cnt++;
        tot++; if (irq !== 1'b0) $display("FAIL periodic_irq got %b exp 0", irq); else pass_cnt++;
    endtask

    task automatic test_ext();
        logic [15:0] v;
        int n;
        wr(0, 2, 16'd4);
        wr(0, 0, 16'h5);
        for (int e = 1; e <= 30; e++) begin
            step();
            n = 0;
            for (int i = 0; i < 4; i++) if (2 + 6 * i + 3 <= e) n++;
            tot++; if (cout[0] !== (e == 23)) $display("FAIL ext_cout e=%0d got %b exp %b", e, cout[0], e == 23); else pass_cnt++;
            peek(0, 3, v);
            tot++; if (v !== 16'(4 - n)) $display("FAIL ext_count e=%0d got %0d exp %0d", e, v, 4 - n); else pass_cnt++;
            pulse_in[0] = e >= 2 && e < 26 && (e - 2) % 6 < 3;
        end
        pulse_in = '0;
        rd_edge(0, 1, v);
        tot++; if (v !== 16'h1) $display("FAIL ext_status got %h exp 1", v); else pass_cnt++;
    endtask

    task automatic test_boundary();
        logic [15:0] v;
        wr(2, 0, 16'h9);
        peek(2, 1, v);
        tot++; if (v !== 16'h4) $display("FAIL zero_load_status got %h exp 4", v); else pass_cnt++;
        peek(2, 0, v);
        tot++; if (v !== 16'h8) $display("FAIL zero_load_ctrl got %h exp 8", v); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step();
            tot++; if (cout[2] !== 1'b0) $display("FAIL zero_load_cout i=%0d got %b exp 0", i, cout[2]); else pass_cnt++;
        end
        rd_edge(2, 1, v);
        peek(2, 1, v);
        tot++; if (v !== 16'h0) $display("FAIL err_clear got %h exp 0", v); else pass_cnt++;
        wr(3, 2, 16'd3);
        wr(3, 0, 16'h9);
        step();
        step();
        rd_edge(3, 1, v);
        tot++; if (v !== 16'h2) $display("FAIL coincide_read got %h exp 2", v); else pass_cnt++;
        peek(3, 1, v);
        tot++; if (v !== 16'h1) $display("FAIL coincide_done got %h exp 1", v); else pass_cnt++;
        tot++; if (irq !== 1'b1) $display("FAIL coincide_irq got %b exp 1", irq); else pass_cnt++;
        rd_edge(3, 1, v);
        wr(3, 2, 16'd2);
        wr(3, 0, 16'h3);
        wr(3, 2, 16'd6);
        wr(3, 0, 16'h0);
        peek(3, 3, v);
        tot++; if (v !== 16'd1) $display("FAIL wr_vs_expire_count got %0d exp 1", v); else pass_cnt++;
        peek(3, 1, v);
        tot++; if (v !== 16'h1) $display("FAIL wr_vs_expire_status got %h exp 1", v); else pass_cnt++;
        rd_edge(3, 1, v);
        wr(5, 2, 16'h55);
        wr(5, 0, 16'h9);
        wr(7, 2, 16'h66);
        wr(6, 0, 16'hF);
        for (int c = 0; c < NUM_CH; c++) begin
            peek(c, 2, v);
            tot++; if (v !== 16'(mload[c])) $display("FAIL bad_idx_load ch=%0d got %h exp %h", c, v, mload[c]); else pass_cnt++;
            peek(c, 1, v);
            tot++; if (v !== 16'h0) $display("FAIL bad_idx_status ch=%0d got %h exp 0", c, v); else pass_cnt++;
            step();
        end
        peek(5, 2, v);
        tot++; if (v !== 16'h0) $display("FAIL bad_idx_read got %h exp 0", v); else pass_cnt++;
        peek(7, 0, v);
        tot++; if (v !== 16'h0) $display("FAIL bad_idx_read7 got %h exp 0", v); else pass_cnt++;
        wr(4, 2, 16'h1FF);
        peek(4, 2, v);
        tot++; if (v !== 16'(mload[4])) $display("FAIL load_width got %h exp %h", v, mload[4]); else pass_cnt++;
        bus.ioread = 1'b1;
        bus.timeraddr = {3'd4, 2'd2};
        #1;
        tot++; if (bus.timerrdata !== 16'h0) $display("FAIL read_no_cs got %h exp 0", bus.timerrdata); else pass_cnt++;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        wr(4, 2, 16'd10);
        wr(4, 0, 16'h1);
        repeat (3) step();
        wr(4, 0, 16'h1);
        peek(4, 3, v);
        tot++; if (v !== 16'd10) $display("FAIL restart_count got %0d exp 10", v); else pass_cnt++;
        for (int j = 1; j <= 11; j++) begin
            if (j == 2) wr(4, 2, 16'd4); else step();
            tot++; if (cout[4] !== (j == 10)) $display("FAIL restart_cout j=%0d got %b exp %b", j, cout[4], j == 10); else pass_cnt++;
        end
        wr(4, 0, 16'h1);
        for (int j = 1; j <= 5; j++) begin
            step();
            tot++; if (cout[4] !== (j == 4)) $display("FAIL newload_cout j=%0d got %b exp %b", j, cout[4], j == 4); else pass_cnt++;
        end
        rd_edge(4, 1, v);
        tot++; if (v !== 16'h1) $display("FAIL b2b_status got %h exp 1", v); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] v;
        int ld [NUM_CH];
        bit per [NUM_CH];
        int st [NUM_CH];
        int fixed [4] = '{2, 3, 5, 255};
        int k;
        int rc;
        bit e;
        int ce;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NUM_CH; c++) wr(c, 0, 16'h0);
            for (int c = 0; c < NUM_CH; c++) begin
                ld[c] = (r == 0 && c < 4) ? fixed[c] : int'($urandom_range(1, 255));
                per[c] = (r == 0 && c < 4) ? 1'b1 : 1'($urandom_range(0, 1));
                wr(c, 2, 16'(ld[c]));
            end
            for (int c = 0; c < NUM_CH; c++) begin
                wr(c, 0, per[c] ? 16'h3 : 16'h1);
                st[c] = cyc;
            end
            for (int n = 0; n < (r == 0 ? 560 : 200); n++) begin
                step();
                for (int c = 0; c < NUM_CH; c++) begin
                    k = cyc - st[c];
                    e = per[c] ? k % ld[c] == 0 : k == ld[c];
                    tot++; if (cout[c] !== e) $display("FAIL rand_cout r=%0d ch=%0d k=%0d got %b exp %b", r, c, k, cout[c], e); else pass_cnt++;
                end
                rc = $urandom_range(0, NUM_CH - 1);
                k = cyc - st[rc];
                ce = per[rc] ? ld[rc] - k % ld[rc] : (k < ld[rc] ? ld[rc] - k : 0);
                peek(rc, 3, v);
                tot++; if (v !== 16'(ce)) $display("FAIL rand_count r=%0d ch=%0d k=%0d got %0d exp %0d", r, rc, k, v, ce); else pass_cnt++;
                tot++; if (v > 16'h00FF) $display("FAIL rand_count_range ch=%0d got %h exp <=00ff", rc, v); else pass_cnt++;
            end
        end
    endtask

    initial begin
        idle();
        foreach (mload[i]) mload[i] = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        test_reset();
        test_oneshot();
        test_periodic();
        test_ext();
        test_boundary();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot);
        $finish;
    end
endmodule
